// File: rtl/mac_seq_ctrl.sv
// Sequential signed multiply-accumulate controller: IDLE/RUN/DONE dot-product engine.
// Define MAC_SEQ_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mac_seq_ctrl #(
    parameter int unsigned N     = 8,
    parameter int unsigned M     = 8,
    parameter int unsigned ACC_W = N + M + 4,
    parameter int unsigned LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [N-1:0]     a,
    input  logic [M-1:0]     b,
    output logic             in_ready,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow
);

    localparam int unsigned PROD_W = N + M;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]           sum;
    logic                     add_ovf;
    logic [ACC_W-1:0]         acc_add;
    logic                     accept;
    logic                     last_pair;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = ACC_W'(prod);

    // One guard bit: the top two bits of sum disagree exactly when the signed add overflows.
    assign sum     = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
    assign add_ovf = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef MAC_SEQ_SAT_EN
    always_comb begin
        acc_add = sum[ACC_W-1:0];
        if (add_ovf) begin
            // sum[ACC_W] carries the true sign of the unbounded result.
            acc_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        acc_add = sum[ACC_W-1:0];
    end
`endif

    assign accept    = (state_q == StRun) && in_valid;
    assign last_pair = (LEN_W'(cnt_q + 1'b1) == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (accept) begin
                    acc_d = acc_add;
                    cnt_d = LEN_W'(cnt_q + 1'b1);
                    ovf_d = ovf_q | add_ovf;
                    if (last_pair) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // start is deliberately not looked at here, even on the handshake cycle.
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StRun);
        busy      = (state_q != StIdle);
        out_valid = (state_q == StDone);
        result    = acc_q;
        overflow  = ovf_q;
    end

endmodule
